multicycle_ctrl: RTL and testbench

- Control FSM that sequences the shared 32-bit ALU and its multicycle RV32I datapath (PC, IR, register file, data memory) through fetch, decode, execute, memory and writeback.
- Decodes the captured instruction into the 4-bit ALU opcode and all datapath enables; waits on data memory through a ready handshake.
- Sits beside the datapath top level; it is the only driver of the ALU op and datapath write strobes.

---
 rtl/multicycle_ctrl_pkg.sv | 31 +++
 rtl/multicycle_ctrl_if.sv | 30 +++
 rtl/multicycle_ctrl_alu_decode.sv | 60 ++++++
 rtl/multicycle_ctrl.sv | 146 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared state, ALU opcode and RV32I opcode encodings
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - datapath-facing signal bundle of the control FSM
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        ir_load;
  logic        alu_src;
  logic [3:0]  alu_ctrl;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic        load_pc;
  logic        pc_src;
  logic        illegal_instr;
  logic        mem_err;
  logic [2:0]  state_o;

  modport ctrl (
    input  instr, zero, mem_ready,
    output ir_load, alu_src, alu_ctrl, mem_read, mem_write, mem_to_reg,
           reg_write, load_pc, pc_src, illegal_instr, mem_err, state_o
  );

  modport dp (
    output instr, zero, mem_ready,
    input  ir_load, alu_src, alu_ctrl, mem_read, mem_write, mem_to_reg,
           reg_write, load_pc, pc_src, illegal_instr, mem_err, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decode.sv
// rtl/multicycle_ctrl_alu_decode.sv - combinational opcode/funct to ALU op and legality
module alu_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] alu_ctrl_o,
  output logic       legal_o
);

  logic [3:0] arith;
  logic       arith_ok;
  logic       f7_base;
  logic       f7_alt;

  assign f7_base = (funct7_i == F7_BASE);
  assign f7_alt  = (funct7_i == F7_ALT);

  // funct7[5] is instr[30], which selects SUB (R only) and SRA (R and I)
  always_comb begin
    arith    = ALU_ADD;
    arith_ok = 1'b1;
    case (funct3_i)
      3'b000:  arith = (opcode_i == OP_R && funct7_i[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  arith = ALU_AND;
      3'b110:  arith = ALU_OR;
      3'b100:  arith = ALU_XOR;
      3'b010:  arith = ALU_SLT;
      3'b001:  arith = ALU_SLL;
      3'b101:  arith = funct7_i[5] ? ALU_SRA : ALU_SRL;
      default: arith_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    legal_o    = 1'b0;
    case (opcode_i)
      OP_R: begin
        alu_ctrl_o = arith;
        legal_o    = arith_ok &&
                     (f7_base || (f7_alt && (funct3_i == 3'b000 || funct3_i == 3'b101)));
      end
      OP_I: begin
        alu_ctrl_o = arith;
        if (funct3_i == 3'b001)      legal_o = arith_ok && f7_base;
        else if (funct3_i == 3'b101) legal_o = arith_ok && (f7_base || f7_alt);
        else                         legal_o = arith_ok;
      end
      OP_LW, OP_SW: legal_o = (funct3_i == 3'b010);
      OP_BEQ: begin
        alu_ctrl_o = ALU_SUB;
        legal_o    = (funct3_i == 3'b000);
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - IF/ID/EX/MEM/WB sequencer for the multicycle RV32I datapath
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.ctrl   bus
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e          state_q, state_d;
  logic [16:0]     ir_q, ir_d;       // {funct7, funct3, opcode}
  logic [CW-1:0]   tmo_q, tmo_d;
  logic            run_q;            // low until the first edge after reset release

  logic [6:0]      opcode;
  logic [3:0]      dec_alu;
  logic            dec_legal;
  logic            is_lw, is_sw, is_beq, is_r;

  logic            ir_load, alu_src, mem_read, mem_write, mem_to_reg;
  logic            reg_write, load_pc, pc_src, illegal_instr, mem_err;
  logic [3:0]      alu_ctrl;

  assign opcode = ir_q[6:0];
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_beq = (opcode == OP_BEQ);
  assign is_r   = (opcode == OP_R);

  alu_decode u_alu_decode (
    .opcode_i   (ir_q[6:0]),
    .funct3_i   (ir_q[9:7]),
    .funct7_i   (ir_q[16:10]),
    .alu_ctrl_o (dec_alu),
    .legal_o    (dec_legal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      ir_q    <= '0;
      tmo_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      tmo_q   <= tmo_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    tmo_d         = '0;
    ir_load       = 1'b0;
    alu_src       = 1'b0;
    alu_ctrl      = 4'b0000;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    load_pc       = 1'b0;
    pc_src        = 1'b0;
    illegal_instr = 1'b0;
    mem_err       = 1'b0;
    if (!run_q) begin
      state_d = S_IF;
    end else begin
      case (state_q)
        S_IF: begin
          ir_load = 1'b1;
          ir_d    = {bus.instr[31:25], bus.instr[14:12], bus.instr[6:0]};
          state_d = S_ID;
        end
        S_ID: begin
          if (dec_legal) begin
            state_d = S_EX;
          end else begin
            illegal_instr = 1'b1;
            load_pc       = 1'b1;
            state_d       = S_IF;
          end
        end
        S_EX: begin
          alu_ctrl = dec_alu;
          alu_src  = !(is_r || is_beq);
          if (is_beq) begin
            load_pc = 1'b1;
            pc_src  = bus.zero;
            state_d = S_IF;
          end else if (is_lw || is_sw) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          mem_read  = is_lw;
          mem_write = is_sw;
          // ready takes priority over a timeout landing in the same cycle
          if (bus.mem_ready) begin
            if (is_lw) begin
              state_d = S_WB;
            end else begin
              load_pc = 1'b1;
              state_d = S_IF;
            end
          end else if (MEM_TIMEOUT != 0 && tmo_q == TMO_LAST) begin
            mem_err = 1'b1;
            load_pc = 1'b1;
            state_d = S_IF;
          end else if (MEM_TIMEOUT != 0) begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_lw;
          load_pc    = 1'b1;
          state_d    = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end
  end

  assign bus.ir_load       = ir_load;
  assign bus.alu_src       = alu_src;
  assign bus.alu_ctrl      = alu_ctrl;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_write     = reg_write;
  assign bus.load_pc       = load_pc;
  assign bus.pc_src        = pc_src;
  assign bus.illegal_instr = illegal_instr;
  assign bus.mem_err       = mem_err;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed and random checks of multicycle_ctrl against a decode table model
module tb_multicycle_ctrl;

  localparam int TMO = 16;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;
  // ALU op indexed by funct3; entry 3 has no mapping and marks the funct as illegal
  localparam logic [3:0] ALU_BY_F3 [8] = '{4'b0010, 4'b1001, 4'b0111, 4'b1111,
                                          4'b1101, 4'b1000, 4'b0001, 4'b0000};

  typedef struct {
    bit       legal;
    int       kind;
    bit [3:0] alu;
  } dec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [16:0] got;
  assign got = {bus.state_o, bus.ir_load, bus.alu_src, bus.alu_ctrl, bus.mem_read,
                bus.mem_write, bus.mem_to_reg, bus.reg_write, bus.load_pc, bus.pc_src,
                bus.illegal_instr, bus.mem_err};

  function automatic logic [16:0] pk(input int st, input bit irl, input bit asrc,
                                     input bit [3:0] alu, input bit mr, input bit mw,
                                     input bit m2r, input bit rw, input bit lpc,
                                     input bit ps, input bit ill, input bit me);
    logic [2:0] s;
    s = st[2:0];
    return {s, irl, asrc, alu, mr, mw, m2r, rw, lpc, ps, ill, me};
  endfunction

  function automatic dec_t ref_dec(input logic [31:0] ins);
    dec_t       d;
    logic [6:0] op, hi;
    int         f3;
    bit         plain, alt;
    op    = ins[6:0];
    f3    = int'(ins[14:12]);
    hi    = ins[31:25];
    plain = (hi == 7'd0);
    alt   = (hi == 7'h20);
    d.legal = 0;
    d.kind  = -1;
    d.alu   = 4'b0010;
    if (op == 7'h33) begin
      d.kind  = K_R;
      d.legal = (f3 != 3) && (plain || (alt && (f3 == 0 || f3 == 5)));
      d.alu   = ALU_BY_F3[f3];
      if (alt && f3 == 0) d.alu = 4'b0110;
      if (alt && f3 == 5) d.alu = 4'b1010;
    end else if (op == 7'h13) begin
      d.kind  = K_I;
      d.legal = (f3 != 3) && ((f3 == 1) ? plain : (f3 == 5) ? (plain || alt) : 1'b1);
      d.alu   = ALU_BY_F3[f3];
      if (f3 == 5 && ins[30]) d.alu = 4'b1010;
    end else if (op == 7'h03) begin
      d.kind  = K_LW;
      d.legal = (f3 == 2);
    end else if (op == 7'h23) begin
      d.kind  = K_SW;
      d.legal = (f3 == 2);
    end else if (op == 7'h63) begin
      d.kind  = K_BEQ;
      d.legal = (f3 == 0);
      d.alu   = 4'b0110;
    end
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic z,
                      input logic rdy, input logic [16:0] exp);
    int nstrobe;
    bus.instr     = ins;
    bus.zero      = z;
    bus.mem_ready = rdy;
    @(negedge clk);
    chk(tag, 32'(got), 32'(exp));
    nstrobe = int'(bus.mem_read) + int'(bus.mem_write) + int'(bus.reg_write);
    chk({tag, "/excl"}, 32'(nstrobe <= 1), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [31:0] ins, input int nwait,
                           input logic z);
    dec_t d;
    bit   mr, mw;
    d = ref_dec(ins);
    step({tag, "/IF"}, ins, 1'($urandom), 1'($urandom), pk(0,1,0,0,0,0,0,0,0,0,0,0));
    if (!d.legal) begin
      step({tag, "/ID"}, $urandom, 1'($urandom), 1'($urandom), pk(1,0,0,0,0,0,0,0,1,0,1,0));
      return;
    end
    step({tag, "/ID"}, $urandom, 1'($urandom), 1'($urandom), pk(1,0,0,0,0,0,0,0,0,0,0,0));
    if (d.kind == K_BEQ) begin
      step({tag, "/EX"}, $urandom, z, 1'($urandom), pk(2,0,0,4'b0110,0,0,0,0,1,z,0,0));
      return;
    end
    step({tag, "/EX"}, $urandom, 1'($urandom), 1'($urandom),
         pk(2,0,(d.kind != K_R),d.alu,0,0,0,0,0,0,0,0));
    if (d.kind == K_R || d.kind == K_I) begin
      step({tag, "/WB"}, $urandom, 1'($urandom), 1'($urandom), pk(4,0,0,0,0,0,0,1,1,0,0,0));
      return;
    end
    mr = (d.kind == K_LW);
    mw = (d.kind == K_SW);
    for (int k = 0; k < TMO; k++) begin
      if (k == nwait) begin
        if (mw) begin
          step({tag, "/MEMrdy"}, $urandom, 1'($urandom), 1'b1, pk(3,0,0,0,0,1,0,0,1,0,0,0));
          return;
        end
        step({tag, "/MEMrdy"}, $urandom, 1'($urandom), 1'b1, pk(3,0,0,0,1,0,0,0,0,0,0,0));
        break;
      end else if (k == TMO - 1) begin
        step({tag, "/MEMtmo"}, $urandom, 1'($urandom), 1'b0, pk(3,0,0,0,mr,mw,0,0,1,0,0,1));
        return;
      end else begin
        step({tag, "/MEMwait"}, $urandom, 1'($urandom), 1'b0, pk(3,0,0,0,mr,mw,0,0,0,0,0,0));
      end
    end
    step({tag, "/WB"}, $urandom, 1'($urandom), 1'($urandom), pk(4,0,0,0,0,0,1,1,1,0,0,0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    int          sel;
    rst           = 1'b0;
    bus.instr     = 32'h0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    #12;
    chk("reset_hold", 32'(got), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_release", 32'(got), 32'd0);
    @(posedge clk);
    #1;

    // LW aborted by reset in its first MEM cycle
    step("lwrst/IF", 32'h0002A303, 1'b0, 1'b1, pk(0,1,0,0,0,0,0,0,0,0,0,0));
    step("lwrst/ID", $urandom, 1'b0, 1'b1, pk(1,0,0,0,0,0,0,0,0,0,0,0));
    step("lwrst/EX", $urandom, 1'b0, 1'b1, pk(2,0,1,4'b0010,0,0,0,0,0,0,0,0));
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("lwrst/MEM", 32'(got), 32'(pk(3,0,0,0,1,0,0,0,0,0,0,0)));
    #2;
    rst = 1'b0;
    #1;
    chk("lwrst/async", 32'(got), 32'd0);
    @(posedge clk);
    #1;
    chk("lwrst/held", 32'(got), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("lwrst/release", 32'(got), 32'd0);
    @(posedge clk);
    #1;

    run_instr("sub",      32'h40B50533, 0, 1'b0);
    run_instr("srai",     32'h4030D093, 0, 1'b0);
    run_instr("srli",     32'h0030D093, 0, 1'b0);
    run_instr("lw_w3",    32'h0002A303, 3, 1'b0);
    run_instr("beq_z1",   32'h00B50463, 0, 1'b1);
    run_instr("beq_z0",   32'h00B50463, 0, 1'b0);
    run_instr("illop",    32'h0000007F, 0, 1'b0);
    run_instr("sw_stuck", 32'h00A2A023, 1000, 1'b0);
    run_instr("sw_w15",   32'h00A2A023, TMO - 1, 1'b0);
    run_instr("lw_w15",   32'h0002A303, TMO - 1, 1'b0);
    run_instr("lw_stuck", 32'h0002A303, 1000, 1'b0);
    run_instr("sw_w0",    32'h00A2A023, 0, 1'b0);
    run_instr("slli_alt", 32'h40309093, 0, 1'b0);
    run_instr("r_mul",    32'h02B50533, 0, 1'b0);
    run_instr("sltu",     32'h00B53533, 0, 1'b0);
    run_instr("lw_f3bad", 32'h0002B303, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ins = $urandom;
      sel = $urandom_range(0, 6);
      case (sel)
        0:       ins[6:0] = 7'h33;
        1, 6:    ins[6:0] = 7'h13;
        2:       ins[6:0] = 7'h03;
        3:       ins[6:0] = 7'h23;
        4:       ins[6:0] = 7'h63;
        default: ins[6:0] = 7'($urandom);
      endcase
      if ($urandom_range(0, 3) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      if ((sel >= 2 && sel <= 4) && $urandom_range(0, 3) != 0)
        ins[14:12] = (sel == 4) ? 3'd0 : 3'd2;
      run_instr($sformatf("rnd%0d_%08h", i, ins), ins, $urandom_range(0, 18), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
